// File: rtl/matrix_stream_reader.sv
// matrix_stream_reader: fetches one matrix from storage, buffers it and streams it row-major over valid/ready.
// Define MATRIX_READ_HEADER_EN to prefix each stream with a {row,col} header beat.
`timescale 1ns/1ps
module matrix_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_SIZE = 5,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               req_row,
  input  logic [2:0]               req_col,
  input  logic [1:0]               req_idx,
  output logic [2:0]               st_req_row,
  output logic [2:0]               st_req_col,
  output logic [1:0]               st_req_idx,
  input  logic                     st_valid,
  input  logic [2:0]               st_row,
  input  logic [2:0]               st_col,
  input  logic [25*DATA_WIDTH-1:0] st_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_eol,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
`ifdef MATRIX_READ_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif
  localparam logic [2:0] MAX_DIM = 3'(MAX_SIZE);
  localparam logic [4:0] LAT_END = 5'(RD_LAT - 1);
  typedef enum logic [1:0] {IDLE, REQ, CHECK, STREAM} state_t;
  state_t state_q, state_d;
  logic [2:0] row_q, row_d, col_q, col_d, c_q, c_d;
  logic [1:0] idx_q, idx_d;
  logic [4:0] lat_q, lat_d, k_q, k_d, n;
  logic hdr_q, hdr_d, done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [25];
  logic [DATA_WIDTH-1:0] mem_d [25];
  logic ok, bad, eol, last;
  assign n = {2'b0, row_q} * {2'b0, col_q};
  assign ok = st_valid && st_row == row_q && st_col == col_q;
  assign bad = req_row == 3'd0 || req_row > MAX_DIM || req_col == 3'd0 || req_col > MAX_DIM;
  assign eol = !hdr_q && c_q == col_q - 3'd1;
  assign last = !hdr_q && k_q == n - 5'd1;
  assign out_data = hdr_q ? DATA_WIDTH'({row_q, col_q}) : mem_q[k_q];
  assign out_eol = state_q == STREAM && eol;
  assign out_last = state_q == STREAM && last;
  assign out_valid = state_q == STREAM;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign st_req_row = row_q;
  assign st_req_col = col_q;
  assign st_req_idx = idx_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    idx_d = idx_q;
    lat_d = lat_q;
    k_d = k_q;
    c_d = c_q;
    hdr_d = hdr_q;
    done_d = 1'b0;
    err_d = 1'b0;
    mem_d = mem_q;
    case (state_q)
      IDLE: if (start) begin
        row_d = req_row;
        col_d = req_col;
        idx_d = req_idx;
        lat_d = 5'd0;
        err_d = bad;
        state_d = bad ? IDLE : REQ;
      end
      REQ: begin
        lat_d = lat_q + 5'd1;
        state_d = lat_q == LAT_END ? CHECK : REQ;
      end
      CHECK: begin
        err_d = !ok;
        state_d = ok ? STREAM : IDLE;
        k_d = 5'd0;
        c_d = 3'd0;
        hdr_d = HDR_EN;
        if (ok) for (int i = 0; i < 25; i++) mem_d[i] = st_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      default: if (out_ready) begin
        if (hdr_q) hdr_d = 1'b0;
        else if (last) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          k_d = k_q + 5'd1;
          c_d = eol ? 3'd0 : c_q + 3'd1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      idx_q <= '0;
      lat_q <= '0;
      k_q <= '0;
      c_q <= '0;
      hdr_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      idx_q <= idx_d;
      lat_q <= lat_d;
      k_q <= k_d;
      c_q <= c_d;
      hdr_q <= hdr_d;
      done_q <= done_d;
      err_q <= err_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_matrix_stream_reader.sv
// tb_matrix_stream_reader: storage model plus beat-queue reference for matrix_stream_reader.
`timescale 1ns/1ps
module tb_matrix_stream_reader;
  localparam int DW = 8;
  localparam int RD_LAT = 1;
  typedef struct {logic [7:0] d; logic e; logic l;} beat_t;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [2:0] req_row = 0, req_col = 0;
  logic [1:0] req_idx = 0;
  logic [2:0] st_req_row, st_req_col, st_row, st_col;
  logic [1:0] st_req_idx;
  logic st_valid, out_valid, out_eol, out_last, busy, done, err;
  logic [25*DW-1:0] st_data;
  logic [DW-1:0] out_data;
  logic [25*DW-1:0] sd [8][8][4];
  logic sv [8][8][4];
  logic [7:0] pipe [RD_LAT];
  logic [2:0] lr, lc;
  logic [1:0] li;
  logic hit;
  beat_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  matrix_stream_reader #(.DATA_WIDTH(DW), .MAX_SIZE(5), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .req_row(req_row), .req_col(req_col), .req_idx(req_idx),
    .st_req_row(st_req_row), .st_req_col(st_req_col), .st_req_idx(st_req_idx),
    .st_valid(st_valid), .st_row(st_row), .st_col(st_col), .st_data(st_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );
  // Storage answers RD_LAT clock edges after the request is driven.
  always @(posedge clk) begin
    pipe[0] <= {st_req_row, st_req_col, st_req_idx};
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  always_comb begin
    {lr, lc, li} = pipe[RD_LAT-1];
    hit = lr >= 3'd1 && lr <= 3'd5 && lc >= 3'd1 && lc <= 3'd5 && sv[lr][lc][li];
    st_valid = hit;
    st_row = hit ? lr : 3'd0;
    st_col = hit ? lc : 3'd0;
    st_data = hit ? sd[lr][lc][li] : '0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input int r, input int c, input int ix, input int mode);
    logic [25*DW-1:0] v = '0;
    for (int k = 0; k < r * c; k++) v[k*8 +: 8] = mode == 0 ? 8'(k + 1) : mode == 2 ? 8'hAB : 8'($urandom);
    sd[r][c][ix] = v;
    sv[r][c][ix] = 1'b1;
  endtask
  task automatic build(input int r, input int c, input int ix);
    logic [25*DW-1:0] v = sd[r][c][ix];
    q.delete();
`ifdef MATRIX_READ_HEADER_EN
    q.push_back('{d: 8'({r[2:0], c[2:0]}), e: 1'b0, l: 1'b0});
`endif
    for (int rr = 0; rr < r; rr++)
      for (int cc = 0; cc < c; cc++)
        q.push_back('{d: v[(rr*c+cc)*8 +: 8], e: cc == c - 1, l: rr == r - 1 && cc == c - 1});
  endtask
  task automatic go(input int r, input int c, input int ix);
    start = 1;
    req_row = 3'(r);
    req_col = 3'(c);
    req_idx = 2'(ix);
    @(negedge clk);
    start = 0;
  endtask
  task automatic run(input int r, input int c, input int ix, input int mode, input bit inj, input bit stale);
    int n = 0, i = 0;
    build(r, c, ix);
    go(r, c, ix);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_beat_latency", n, RD_LAT + 1);
    while (q.size() > 0 && i < 400) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(i % 3 == 0) : 1'($urandom);
      check("valid", out_valid, 1);
      check("data", out_data, q[0].d);
      check("eol", out_eol, q[0].e);
      check("last", out_last, q[0].l);
      check("busy", busy, 1);
      if (inj && i == 2) begin
        start = 1;
        req_row = 3'd1;
        req_col = 3'd1;
        req_idx = 2'd0;
      end
      if (stale && i == 1) put(r, c, ix, 1);
      if (out_ready) void'(q.pop_front());
      @(negedge clk);
      start = 0;
      i++;
    end
    check("beats_remaining", q.size(), 0);
    check("done", done, 1);
    check("valid_after_last", out_valid, 0);
    check("busy_after_last", busy, 0);
    check("err_with_done", err, 0);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask
  task automatic bad(input int r, input int c);
    go(r, c, 0);
    check("bad_err", err, 1);
    check("bad_busy", busy, 0);
    @(negedge clk);
    check("bad_err_pulse", err, 0);
    check("bad_busy_after", busy, 0);
  endtask
  initial begin
    int n;
    for (int a = 0; a < 8; a++) for (int b = 0; b < 8; b++) for (int x = 0; x < 4; x++) begin
      sv[a][b][x] = 1'b0;
      sd[a][b][x] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_st_req", {st_req_row, st_req_col, st_req_idx}, 0);
    rst = 0;
    @(negedge clk);
    put(2, 3, 0, 0);
    run(2, 3, 0, 0, 0, 0);
    build(2, 3, 0);
    run(2, 3, 0, 1, 1, 1);
    bad(0, 3);
    bad(6, 3);
    bad(3, 7);
    go(2, 2, 3);
    n = 0;
    while (!err && n < 10) begin
      check("empty_no_valid", out_valid, 0);
      @(negedge clk);
      n++;
    end
    check("empty_err_latency", n, RD_LAT + 1);
    check("empty_done", done, 0);
    check("empty_busy", busy, 0);
    @(negedge clk);
    check("empty_err_pulse", err, 0);
    put(5, 5, 1, 1);
    out_ready = 1;
    go(5, 5, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_err", err, 0);
      check("post_rst_valid", out_valid, 0);
    end
    run(5, 5, 1, 2, 0, 0);
    put(1, 1, 2, 2);
    run(1, 1, 2, 0, 0, 0);
    for (int t = 0; t < 6; t++) begin
      int r = $urandom_range(1, 5), c = $urandom_range(1, 5), ix = $urandom_range(0, 3);
      put(r, c, ix, 1);
      run(r, c, ix, 2, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
